fir_readout_ctrl: RTL and testbench

Synthesizable readout sequencer for the RNS FIR filter tops (fir_top_64 and wider/deeper variants). It waits for the filter's done flag and walks the filter's register-read port (regAddr/regData) over DEPTH result words with a configurable read latency. Each word is streamed out over a valid/ready handshake, and the block accumulates a modular checksum. A cycle-count watchdog aborts the run if done never arrives.

---
 rtl/fir_readout_pkg.sv | 17 +
 rtl/fir_readout_watchdog.sv | 29 ++
 rtl/fir_readout_ctrl.sv | 137 +++++++++++++
 tb/tb_fir_readout_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fir_readout_pkg.sv
// fir_readout_pkg: shared state encoding, default parameters and watchdog sizing for the readout controllers.
package fir_readout_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_DONE, ISSUE, WAIT_LAT, CAPTURE, PUSH} state_t;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DEPTH          = 64;
    localparam int DEF_READ_LAT       = 1;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int LAT_W              = 3;

    function automatic int wd_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/fir_readout_watchdog.sv
// fir_readout_watchdog: cycle counter; expired marks the enabled cycle on which count reaches TIMEOUT_CYCLES,
// so a controller leaving on expired spends exactly TIMEOUT_CYCLES enabled cycles waiting.
module fir_readout_watchdog
    import fir_readout_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = wd_width(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != W'(TIMEOUT_CYCLES))
            count <= count + 1'b1;

endmodule

// File: rtl/fir_readout_ctrl.sv
// fir_readout_ctrl: waits for the filter's done flag, reads DEPTH result words through the register port
// and streams them over valid/ready while accumulating a wrapping checksum.
module fir_readout_ctrl
    import fir_readout_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int READ_LAT       = DEF_READ_LAT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              finished,
    output logic              timeout,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] word_cnt
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d, cnt_d;
    logic [DATA_W-1:0] data_d, sum_d;
    logic [LAT_W-1:0]  lat, lat_d;
    logic              valid_d, busy_d, finished_d, timeout_d;
    logic              wd_clear, wd_en, wd_expired;

    assign wd_clear = (state == IDLE) && start;
    assign wd_en    = (state == WAIT_DONE) && !done;

    fir_readout_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            regAddr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            timeout   <= 1'b0;
            checksum  <= '0;
            word_cnt  <= '0;
            lat       <= '0;
        end else begin
            state     <= state_d;
            regAddr   <= addr_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            finished  <= finished_d;
            timeout   <= timeout_d;
            checksum  <= sum_d;
            word_cnt  <= cnt_d;
            lat       <= lat_d;
        end

    always_comb begin
        state_d    = state;
        addr_d     = regAddr;
        data_d     = out_data;
        valid_d    = out_valid;
        busy_d     = busy;
        finished_d = finished;
        timeout_d  = timeout;
        sum_d      = checksum;
        cnt_d      = word_cnt;
        lat_d      = lat;
        case (state)
            IDLE:
                if (start) begin
                    state_d    = WAIT_DONE;
                    finished_d = 1'b0;
                    timeout_d  = 1'b0;
                    sum_d      = '0;
                    cnt_d      = '0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                end
            WAIT_DONE:
                if (done)
                    state_d = ISSUE;
                else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end
            ISSUE:
                if (READ_LAT == 0)
                    state_d = CAPTURE;
                else begin
                    lat_d   = LAT_W'(READ_LAT);
                    state_d = WAIT_LAT;
                end
            WAIT_LAT: begin
                lat_d   = lat - 1'b1;
                state_d = (lat == LAT_W'(1)) ? CAPTURE : WAIT_LAT;
            end
            CAPTURE: begin
                data_d  = regData;
                valid_d = 1'b1;
                state_d = PUSH;
            end
            PUSH:
                if (out_ready) begin
                    sum_d   = checksum + out_data;
                    cnt_d   = word_cnt + 1'b1;
                    valid_d = 1'b0;
                    // last word: leave regAddr at DEPTH-1 rather than wrapping
                    if (word_cnt == ADDR_W'(DEPTH - 1)) begin
                        state_d    = IDLE;
                        finished_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        addr_d  = regAddr + 1'b1;
                        state_d = ISSUE;
                    end
                end
            default:
                state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_readout_ctrl.sv
// tb_fir_readout_ctrl: directed checks of the readout sequencer: full runs, timeout, backpressure,
// wrapping checksum, per-word cycle cost, async reset mid-run and ignored restarts.
module tb_fir_readout_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        start_a, done_a, out_ready_a;
    logic [31:0] regAddr_a, regData_a, out_data_a, checksum_a, word_cnt_a;
    logic        out_valid_a, busy_a, finished_a, timeout_a;

    logic        start_b, done_b;
    logic [31:0] regAddr_b, word_cnt_b, regAddr_c, word_cnt_c;
    logic [7:0]  out_data_b, checksum_b, out_data_c, checksum_c;
    logic        out_valid_b, busy_b, finished_b, timeout_b;
    logic        out_valid_c, busy_c, finished_c, timeout_c;

    assign regData_a = regAddr_a * 3;

    fir_readout_ctrl dut (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a),
        .regAddr(regAddr_a), .regData(regData_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .busy(busy_a), .finished(finished_a), .timeout(timeout_a),
        .checksum(checksum_a), .word_cnt(word_cnt_a)
    );

    fir_readout_ctrl #(.DATA_W(8), .DEPTH(4), .READ_LAT(0)) dut_l0 (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b),
        .regAddr(regAddr_b), .regData(8'hFF),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(1'b1),
        .busy(busy_b), .finished(finished_b), .timeout(timeout_b),
        .checksum(checksum_b), .word_cnt(word_cnt_b)
    );

    fir_readout_ctrl #(.DATA_W(8), .DEPTH(4), .READ_LAT(3)) dut_l3 (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b),
        .regAddr(regAddr_c), .regData(8'hFF),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(1'b1),
        .busy(busy_c), .finished(finished_c), .timeout(timeout_c),
        .checksum(checksum_c), .word_cnt(word_cnt_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,0,0,...
    task automatic run_a(input int mode, input bit pulse_mid, input string tag);
        int idx = 0;
        bit pv = 0, ph = 0;
        @(negedge clk);
        start_a = 1'b1; done_a = 1'b0; out_ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk({tag, "_busy"}, busy_a, 1);
        chk({tag, "_fin_clr"}, finished_a, 0);
        chk({tag, "_to_clr"}, timeout_a, 0);
        repeat (4) @(negedge clk);
        done_a = 1'b1;
        for (int c = 0; c < 5000 && !finished_a; c++) begin
            @(negedge clk);
            out_ready_a = (mode == 0) ? 1'b1 : (c % 3 == 0);
            start_a = pulse_mid && (c == 50 || c == 51);
            if (pv && !ph && !out_valid_a)
                chk({tag, "_valid_drop"}, out_valid_a, 1);
            if (out_valid_a)
                chk({tag, "_data"}, out_data_a, idx * 3);
            ph = out_valid_a && out_ready_a;
            pv = out_valid_a;
            if (ph) idx++;
        end
        start_a = 1'b0;
        chk({tag, "_words"}, idx, 64);
        chk({tag, "_finished"}, finished_a, 1);
        chk({tag, "_busy_end"}, busy_a, 0);
        chk({tag, "_word_cnt"}, word_cnt_a, 64);
        chk({tag, "_checksum"}, checksum_a, 6048);
        chk({tag, "_regAddr"}, regAddr_a, 63);
        chk({tag, "_timeout"}, timeout_a, 0);
    endtask

    initial begin
        int last_b, last_c;
        bit seen_valid, found;
        reset = 1'b1;
        start_a = 1'b0; done_a = 1'b0; out_ready_a = 1'b1;
        start_b = 1'b0; done_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_regAddr", regAddr_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_finished", finished_a, 0);
        chk("rst_checksum", checksum_a, 0);
        reset = 1'b0;

        run_a(0, 1'b0, "s1");

        // done never arrives: abort exactly 1000 cycles after entering WAIT_DONE
        @(negedge clk);
        start_a = 1'b1; done_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        chk("s2_fin_clr", finished_a, 0);
        seen_valid = 1'b0;
        for (int c = 0; c < 999; c++) begin
            @(negedge clk);
            seen_valid |= out_valid_a;
        end
        chk("s2_to_early", timeout_a, 0);
        chk("s2_busy_early", busy_a, 1);
        @(negedge clk);
        chk("s2_timeout", timeout_a, 1);
        chk("s2_busy", busy_a, 0);
        chk("s2_finished", finished_a, 0);
        chk("s2_no_valid", seen_valid, 0);

        run_a(1, 1'b0, "s3");

        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        last_b = -1; last_c = -1;
        for (int c = 0; c < 200 && !(finished_b && finished_c); c++) begin
            @(negedge clk);
            if (out_valid_b) begin
                chk("s4_l0_data", out_data_b, 8'hFF);
                if (last_b >= 0) chk("s4_l0_gap", c - last_b, 3);
                last_b = c;
            end
            if (out_valid_c) begin
                chk("s4_l3_data", out_data_c, 8'hFF);
                if (last_c >= 0) chk("s4_l3_gap", c - last_c, 6);
                last_c = c;
            end
        end
        chk("s4_l0_checksum", checksum_b, 8'hFC);
        chk("s4_l0_word_cnt", word_cnt_b, 4);
        chk("s4_l0_regAddr", regAddr_b, 3);
        chk("s4_l0_finished", finished_b, 1);
        chk("s4_l3_checksum", checksum_c, 8'hFC);
        chk("s4_l3_word_cnt", word_cnt_c, 4);
        chk("s4_l3_finished", finished_c, 1);
        chk("s4_timeouts", {timeout_b, timeout_c, busy_b, busy_c}, 0);

        // async reset while word 10 sits in PUSH
        @(negedge clk);
        start_a = 1'b1; done_a = 1'b1; out_ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (out_valid_a && regAddr_a == 10) found = 1'b1;
        end
        out_ready_a = 1'b0;
        chk("s5_reached_word10", found, 1);
        chk("s5_pre_word_cnt", word_cnt_a, 10);
        #2 reset = 1'b1;
        #1;
        chk("s5_regAddr", regAddr_a, 0);
        chk("s5_out_data", out_data_a, 0);
        chk("s5_out_valid", out_valid_a, 0);
        chk("s5_busy", busy_a, 0);
        chk("s5_flags", {finished_a, timeout_a}, 0);
        chk("s5_checksum", checksum_a, 0);
        chk("s5_word_cnt", word_cnt_a, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready_a = 1'b1;
        run_a(0, 1'b0, "s5");

        run_a(0, 1'b1, "s6");
        repeat (10) @(negedge clk);
        chk("s6_no_restart_busy", busy_a, 0);
        chk("s6_no_restart_cnt", word_cnt_a, 64);
        chk("s6_still_finished", finished_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
